// File: rtl/codon_counter_multi.sv
// codon_counter_multi
//   Streams 4-bit nucleotide nibbles from a synchronous genome memory and
//   counts, per channel, how often a programmable pattern of up to MAX_LEN
//   nibbles occurs. Matches may overlap. A single 0xF separates sequences
//   (no match spans it); two consecutive 0xF end the genome.
//
// Ports
//   clock_i          rising-edge clock
//   reset_i          asynchronous active-high reset
//   start_i          begin a scan (honoured in IDLE and DONE only)
//   cfg_we_i         pattern nibble write strobe (ignored during RUN)
//   cfg_sel_i        pattern channel to write
//   cfg_pos_i        nibble position within the pattern
//   cfg_data_i       pattern nibble value
//   mem_en_o         genome memory read enable
//   mem_addr_o       genome memory read address
//   mem_rdata_i      genome read data, one cycle after the address
//   count_index_i    channel selected for read-out
//   count_o          count of the selected channel (0 if out of range)
//   busy_o           scan in progress
//   done_o           scan complete, held until the next start
//   addr_overflow_o  scan ended because the address space ran out
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | after reset; patterns writable, waiting for start
// RUN    | issuing addresses and evaluating one nibble per cycle
// DONE   | counts frozen, patterns writable, start triggers a rescan
module codon_counter_multi #(
  parameter int NUM_CODONS  = 5,
  parameter int MAX_LEN     = 4,
  parameter int COUNT_WIDTH = 8,
  parameter int ADDR_WIDTH  = 8,
  localparam int SEL_W = (NUM_CODONS > 1) ? $clog2(NUM_CODONS) : 1,
  localparam int POS_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic                   cfg_we_i,
  input  logic [SEL_W-1:0]       cfg_sel_i,
  input  logic [POS_W-1:0]       cfg_pos_i,
  input  logic [3:0]             cfg_data_i,
  output logic                   mem_en_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  input  logic [3:0]             mem_rdata_i,
  input  logic [SEL_W-1:0]       count_index_i,
  output logic [COUNT_WIDTH-1:0] count_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   addr_overflow_o
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [ADDR_WIDTH-1:0]  ADDR_LAST = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [NUM_CODONS-1:0][MAX_LEN-1:0][3:0] pat_q;
  logic [NUM_CODONS-1:0][COUNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [MAX_LEN-1:0][3:0]                 hist_q, hist_d, hist_new;
  logic [LEN_W-1:0]                        depth_q, depth_d, depth_new;
  logic [ADDR_WIDTH-1:0]                   addr_q, addr_d;
  logic                                    prev_sep_q, prev_sep_d;
  logic                                    prime_q, prime_d;
  logic                                    top_q, top_d;
  logic                                    ovf_q, ovf_d;

  logic [NUM_CODONS-1:0][LEN_W-1:0] pat_len;
  logic [NUM_CODONS-1:0]            hit;
  logic                             nib_sep;
  logic                             cfg_ok;

  assign nib_sep = (mem_rdata_i == 4'hF);

  // Candidate history after shifting the current nibble in, plus the
  // per-channel hit decision against that candidate.
  always_comb begin
    hist_new[0] = mem_rdata_i;
    for (int p = 1; p < MAX_LEN; p++) begin
      hist_new[p] = hist_q[p-1];
    end
    depth_new = (depth_q == LEN_W'(MAX_LEN)) ? depth_q : depth_q + 1'b1;

    for (int i = 0; i < NUM_CODONS; i++) begin
      // Length is the position of the first 0xF; scanning downward leaves
      // the lowest such position.
      pat_len[i] = LEN_W'(MAX_LEN);
      for (int p = MAX_LEN - 1; p >= 0; p--) begin
        if (pat_q[i][p] == 4'hF) pat_len[i] = LEN_W'(p);
      end
    end

    for (int i = 0; i < NUM_CODONS; i++) begin
      hit[i] = 1'b0;
      for (int l = 1; l <= MAX_LEN; l++) begin
        if (pat_len[i] == LEN_W'(l) && depth_new >= LEN_W'(l)) begin
          hit[i] = 1'b1;
          // Newest nibble pairs with the last pattern nibble.
          for (int p = 0; p < l; p++) begin
            if (hist_new[p] != pat_q[i][l-1-p]) hit[i] = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hist_d     = hist_q;
    depth_d    = depth_q;
    addr_d     = addr_q;
    prev_sep_d = prev_sep_q;
    prime_d    = prime_q;
    top_d      = top_q;
    ovf_d      = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d    = S_RUN;
          cnt_d      = '0;
          hist_d     = '0;
          depth_d    = '0;
          addr_d     = '0;
          prev_sep_d = 1'b0;
          prime_d    = 1'b1;
          top_d      = 1'b0;
          ovf_d      = 1'b0;
        end
      end

      S_RUN: begin
        if (addr_q == ADDR_LAST) top_d = 1'b1;
        else                     addr_d = addr_q + 1'b1;
        prime_d = 1'b0;

        // The first RUN cycle only presents address 0; its read data is stale.
        if (!prime_q) begin
          if (nib_sep) begin
            if (prev_sep_q) begin
              state_d = S_DONE;
            end else begin
              depth_d    = '0;
              prev_sep_d = 1'b1;
            end
          end else begin
            prev_sep_d = 1'b0;
            hist_d     = hist_new;
            depth_d    = depth_new;
            for (int i = 0; i < NUM_CODONS; i++) begin
              if (hit[i] && cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
          // top_q means the data now on mem_rdata came from the last address.
          if (top_q && !(nib_sep && prev_sep_q)) begin
            state_d = S_DONE;
            ovf_d   = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hist_q     <= '0;
      depth_q    <= '0;
      addr_q     <= '0;
      prev_sep_q <= 1'b0;
      prime_q    <= 1'b0;
      top_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hist_q     <= hist_d;
      depth_q    <= depth_d;
      addr_q     <= addr_d;
      prev_sep_q <= prev_sep_d;
      prime_q    <= prime_d;
      top_q      <= top_d;
      ovf_q      <= ovf_d;
    end
  end

  assign cfg_ok = cfg_we_i && (state_q != S_RUN) &&
                  ({1'b0, cfg_sel_i} < (SEL_W+1)'(NUM_CODONS)) &&
                  ({1'b0, cfg_pos_i} < (POS_W+1)'(MAX_LEN));

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      pat_q <= '1;
    end else if (cfg_ok) begin
      pat_q[cfg_sel_i][cfg_pos_i] <= cfg_data_i;
    end
  end

  always_comb begin
    count_o = '0;
    if ({1'b0, count_index_i} < (SEL_W+1)'(NUM_CODONS)) count_o = cnt_q[count_index_i];
  end

  assign mem_en_o        = (state_q == S_RUN);
  assign busy_o          = (state_q == S_RUN);
  assign done_o          = (state_q == S_DONE);
  assign mem_addr_o      = addr_q;
  assign addr_overflow_o = ovf_q;

endmodule

// File: tb/tb_codon_counter_multi.sv
module tb_codon_counter_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b, start_c;
  logic       cfg_we;
  logic [2:0] cfg_sel;
  logic [1:0] cfg_pos;
  logic [3:0] cfg_data;
  logic [2:0] count_index;

  logic       mem_en_a, mem_en_b, mem_en_c;
  logic [7:0] mem_addr_a;
  logic [3:0] mem_addr_b, mem_addr_c;
  logic [3:0] rdata_a, rdata_b, rdata_c;
  logic [7:0] count_a;
  logic [1:0] count_b;
  logic [3:0] count_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic       ovf_a, ovf_b, ovf_c;

  logic [3:0] mem_a [256];
  logic [3:0] mem_b [16];
  logic [3:0] mem_c [16];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rdata_a <= mem_a[mem_addr_a];
  always @(posedge clk) rdata_b <= mem_b[mem_addr_b];
  always @(posedge clk) rdata_c <= mem_c[mem_addr_c];

  codon_counter_multi #(.NUM_CODONS(5), .MAX_LEN(4), .COUNT_WIDTH(8), .ADDR_WIDTH(8)) dut_a (
    .clock_i(clk), .reset_i(rst), .start_i(start_a), .cfg_we_i(cfg_we), .cfg_sel_i(cfg_sel),
    .cfg_pos_i(cfg_pos), .cfg_data_i(cfg_data), .mem_en_o(mem_en_a), .mem_addr_o(mem_addr_a),
    .mem_rdata_i(rdata_a), .count_index_i(count_index), .count_o(count_a), .busy_o(busy_a),
    .done_o(done_a), .addr_overflow_o(ovf_a));

  codon_counter_multi #(.NUM_CODONS(5), .MAX_LEN(4), .COUNT_WIDTH(2), .ADDR_WIDTH(4)) dut_b (
    .clock_i(clk), .reset_i(rst), .start_i(start_b), .cfg_we_i(cfg_we), .cfg_sel_i(cfg_sel),
    .cfg_pos_i(cfg_pos), .cfg_data_i(cfg_data), .mem_en_o(mem_en_b), .mem_addr_o(mem_addr_b),
    .mem_rdata_i(rdata_b), .count_index_i(count_index), .count_o(count_b), .busy_o(busy_b),
    .done_o(done_b), .addr_overflow_o(ovf_b));

  codon_counter_multi #(.NUM_CODONS(5), .MAX_LEN(4), .COUNT_WIDTH(4), .ADDR_WIDTH(4)) dut_c (
    .clock_i(clk), .reset_i(rst), .start_i(start_c), .cfg_we_i(cfg_we), .cfg_sel_i(cfg_sel),
    .cfg_pos_i(cfg_pos), .cfg_data_i(cfg_data), .mem_en_o(mem_en_c), .mem_addr_o(mem_addr_c),
    .mem_rdata_i(rdata_c), .count_index_i(count_index), .count_o(count_c), .busy_o(busy_c),
    .done_o(done_c), .addr_overflow_o(ovf_c));

  typedef struct {
    logic [15:0] p0;    // channel 0 pattern, position 0 in bits [3:0]
    logic [15:0] p1;    // channel 1 pattern
    logic [63:0] mem;   // nibble at address k in bits [4k+3:4k]
    int          n;     // nibbles up to and including the second terminator
    int          e0;
    int          e1;
  } vec_t;

  vec_t vecs [5];

  function automatic logic done_of(input int w);
    case (w)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      0: return busy_a;
      1: return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic [31:0] count_of(input int w);
    case (w)
      0: return 32'(count_a);
      1: return 32'(count_b);
      default: return 32'(count_c);
    endcase
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      0: start_a = v;
      1: start_b = v;
      default: start_c = v;
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_pat(input int ch, input logic [15:0] p);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cfg_we   = 1'b1;
      cfg_sel  = 3'(ch);
      cfg_pos  = 2'(k);
      cfg_data = p[k*4 +: 4];
    end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // lat = cycles from the start-sampling cycle to the first cycle with done high
  task automatic run_scan(input int w, input bit poke, output int lat);
    bit saw_top;
    bit wrapped;
    saw_top = 1'b0;
    wrapped = 1'b0;
    @(negedge clk);
    set_start(w, 1'b1);
    @(posedge clk);
    #1;
    set_start(w, 1'b0);
    lat = 1;
    check("busy_in_run", 32'(busy_of(w)), 32'd1);
    check("done_low_in_run", 32'(done_of(w)), 32'd0);
    while (!done_of(w) && lat < 400) begin
      if (poke && lat == 3) begin
        set_start(w, 1'b1);
        cfg_we = 1'b1; cfg_sel = 3'd0; cfg_pos = 2'd0; cfg_data = 4'h9;
      end else if (poke && lat == 4) begin
        set_start(w, 1'b0);
        cfg_we = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (w == 2) begin
        if (mem_addr_c == 4'hF) saw_top = 1'b1;
        else if (saw_top) wrapped = 1'b1;
      end
    end
    set_start(w, 1'b0);
    cfg_we = 1'b0;
    if (!done_of(w)) begin
      checks++;
      failures++;
      $display("FAIL scan_timeout: dut %0d never raised done within %0d cycles", w, lat);
    end
    if (w == 2) check("no_addr_wrap", 32'(wrapped), 32'd0);
  endtask

  task automatic check_count(input string name, input int w, input int ch, input int exp);
    count_index = 3'(ch);
    #1;
    check(name, count_of(w), 32'(exp));
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    cfg_we = 1'b0; cfg_sel = '0; cfg_pos = '0; cfg_data = '0; count_index = '0;
    for (int k = 0; k < 256; k++) mem_a[k] = 4'hF;
    for (int k = 0; k < 16; k++) begin mem_b[k] = 4'hF; mem_c[k] = 4'hF; end

    //                 p0        p1        memory (addr0 = LS nibble)   n  e0 e1
    vecs[0] = '{16'hF321, 16'hFFFF, 64'hFFFF_FFFF_FF32_1321, 8, 2, 0};
    vecs[1] = '{16'hFF22, 16'hFFF2, 64'hFFFF_FFFF_FFFF_F222, 5, 2, 3};
    vecs[2] = '{16'hFF21, 16'hFFFF, 64'hFFFF_FFFF_FFF2_12F1, 7, 1, 0};
    vecs[3] = '{16'h4321, 16'hFF43, 64'hFFFF_FFFF_FF43_4321, 8, 1, 2};
    vecs[4] = '{16'hFF65, 16'hFF56, 64'hFFFF_FFFF_FF65_65F6, 8, 2, 1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_en_a", 32'(mem_en_a), 0);
    check("rst_mem_addr_a", 32'(mem_addr_a), 0);
    check("rst_busy_a", 32'(busy_a), 0);
    check("rst_done_a", 32'(done_a), 0);
    check("rst_ovf_a", 32'(ovf_a), 0);
    check("rst_busy_b", 32'(busy_b), 0);
    check("rst_done_c", 32'(done_c), 0);
    check_count("rst_count_a0", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < 16; k++) mem_a[k] = vecs[v].mem[k*4 +: 4];
      set_pat(0, vecs[v].p0);
      set_pat(1, vecs[v].p1);
      run_scan(0, 1'b0, lat);
      check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].n + 2));
      check($sformatf("v%0d_ovf", v), 32'(ovf_a), 0);
      check($sformatf("v%0d_busy_done", v), 32'(busy_a), 0);
      check($sformatf("v%0d_mem_en_done", v), 32'(mem_en_a), 0);
      check_count($sformatf("v%0d_count0", v), 0, 0, vecs[v].e0);
      check_count($sformatf("v%0d_count1", v), 0, 1, vecs[v].e1);
      for (int ch = 2; ch < 5; ch++) check_count($sformatf("v%0d_count%0d", v, ch), 0, ch, 0);
      check_count($sformatf("v%0d_count_idx5", v), 0, 5, 0);
      check_count($sformatf("v%0d_count_idx7", v), 0, 7, 0);
    end

    // Saturation (2-bit counts) and a channel disabled by nibble 0 = 0xF.
    for (int k = 0; k < 5; k++) mem_b[k] = 4'h3;
    set_pat(0, 16'hFFF3);
    set_pat(1, 16'h333F);
    run_scan(1, 1'b0, lat);
    check("sat_latency", 32'(lat), 9);
    check_count("sat_count0", 1, 0, 3);
    check_count("sat_count1_disabled", 1, 1, 0);
    check("sat_ovf", 32'(ovf_b), 0);

    // Address exhaustion: 16 nibbles of 1, no terminator, 4-bit counts.
    for (int k = 0; k < 16; k++) mem_c[k] = 4'h1;
    set_pat(0, 16'hFFF1);
    set_pat(1, 16'hFFFF);
    run_scan(2, 1'b0, lat);
    check("ovf_latency", 32'(lat), 18);
    check("ovf_flag", 32'(ovf_c), 1);
    check("ovf_mem_addr", 32'(mem_addr_c), 15);
    check("ovf_mem_en", 32'(mem_en_c), 0);
    check_count("ovf_count0", 2, 0, 15);
    // Second terminator exactly at the last address ends normally.
    mem_c[14] = 4'hF;
    mem_c[15] = 4'hF;
    run_scan(2, 1'b0, lat);
    check("edge_term_latency", 32'(lat), 18);
    check("edge_term_ovf", 32'(ovf_c), 0);
    check_count("edge_term_count0", 2, 0, 14);

    // Reset three cycles into a scan, then rescan.
    for (int k = 0; k < 16; k++) mem_a[k] = vecs[0].mem[k*4 +: 4];
    set_pat(0, 16'hF321);
    set_pat(1, 16'hFFFF);
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_busy", 32'(busy_a), 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy_a), 0);
    check("mid_rst_mem_en", 32'(mem_en_a), 0);
    check("mid_rst_mem_addr", 32'(mem_addr_a), 0);
    check("mid_rst_done", 32'(done_a), 0);
    check("mid_rst_ovf", 32'(ovf_a), 0);
    @(negedge clk);
    rst = 1'b0;
    // Patterns went back to 0xF, so every channel is disabled.
    run_scan(0, 1'b0, lat);
    check("post_rst_latency", 32'(lat), 10);
    check_count("post_rst_count0", 0, 0, 0);
    set_pat(0, 16'hF321);
    // start and a pattern write pulsed mid-scan must both be ignored.
    run_scan(0, 1'b1, lat);
    check("rescan_latency", 32'(lat), 10);
    check_count("rescan_count0", 0, 0, 2);
    repeat (5) @(posedge clk);
    #1;
    check("hold_done", 32'(done_a), 1);
    check_count("hold_count0", 0, 0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
